wb_multi_counter: RTL and testbench

//   NCH-channel programmable up/down counter/timer, successor to the single 16-bit counter in the user project.

---
 rtl/wb_multi_counter.sv | 227 ++++++++++++++++++++++
 tb/tb_wb_multi_counter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_multi_counter.sv
// wb_multi_counter: NCH-channel programmable up/down counter/timer on a Wishbone slave port.
//   Per channel: CTRL (en, dir, oneshot, ie), VALUE, LIMIT, STATUS (sticky tc, write-1-to-clear).
//   Register map: adr[7:4] = channel, adr[3:2] = register (CTRL, VALUE, LIMIT, STATUS);
//   adr[7:4] = 0xF, register 0 = PRESC. Unmapped addresses read 0, ignore writes, and are still acked.
//   Optional feature macro: MCNT_PRESCALER_EN enables a PSW-bit global tick prescaler.
// Ports:
//   wb_clk_i, wb_rst_i           clock, asynchronous active-high reset
//   wbs_*                        Wishbone slave (cyc, stb, we, sel, adr, dat_i / ack, dat_o)
//   la_data_in, la_oenb          per-channel external gate (la_data_in[c] counts when la_oenb[c] = 0)
//   la_data_out                  packed channel counts, channel 0 in the low bits
//   io_out, io_oeb               channel 0 count; output enables follow reset
//   irq                          [0] = any unmasked terminal-count status, [2:1] = 0
module wb_multi_counter #(
    parameter int unsigned BITS = 16,
    parameter int unsigned NCH  = 4,
    parameter int unsigned PSW  = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [127:0]    la_data_in,
    input  logic [127:0]    la_oenb,
    output logic [127:0]    la_data_out,
    output logic [BITS-1:0] io_out,
    output logic [BITS-1:0] io_oeb,
    output logic [2:0]      irq
);
    localparam int unsigned LAW = 128;

    // Replace the bytes of old_v selected by sel with the matching bytes of new_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    logic [NCH-1:0]  en_q, en_d, dir_q, dir_d, os_q, os_d, ie_q, ie_d, tc_q, tc_d;
    logic [BITS-1:0] value_q [NCH];
    logic [BITS-1:0] value_d [NCH];
    logic [BITS-1:0] limit_q [NCH];
    logic [BITS-1:0] limit_d [NCH];
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic            irq_q, irq_d;

    logic        acc_c, wr_c, presc_hit_c, tick_c;
    logic [3:0]  chan_c;
    logic [1:0]  reg_c;
    logic [31:0] rdata_c, presc_rd_c;
    logic        unused_bits;

    // A transfer is accepted once per ack; the cycle after an ack never accepts.
    assign acc_c       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_c        = acc_c & wbs_we_i;
    assign chan_c      = wbs_adr_i[7:4];
    assign reg_c       = wbs_adr_i[3:2];
    assign presc_hit_c = (chan_c == 4'hF) && (reg_c == 2'd0);
    assign unused_bits = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], la_data_in[LAW-1:NCH], la_oenb[LAW-1:NCH]};

`ifdef MCNT_PRESCALER_EN
    logic [PSW-1:0] presc_q, presc_d, pcnt_q, pcnt_d;

    // Global tick every PRESC+1 clocks; a PRESC write restarts the count.
    always_comb begin
        presc_d = presc_q;
        tick_c  = (pcnt_q == presc_q);
        pcnt_d  = tick_c ? '0 : pcnt_q + PSW'(1);
        if (wr_c && presc_hit_c) begin
            presc_d = PSW'(byte_merge(32'(presc_q), wbs_dat_i, wbs_sel_i));
            pcnt_d  = '0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign presc_rd_c = 32'(presc_q);
`else
    logic [PSW-1:0] unused_psw;

    // Without a prescaler every clock is a tick; unused_psw keeps PSW referenced.
    assign tick_c     = 1'b1;
    assign presc_rd_c = '0;
    assign unused_psw = '0;
`endif

    // Read mux; anything not decoded returns zero.
    always_comb begin
        rdata_c = '0;
        if (presc_hit_c) rdata_c = presc_rd_c;
        for (int c = 0; c < NCH; c++) begin
            if (chan_c == 4'(c)) begin
                case (reg_c)
                    2'd0:    rdata_c = {28'd0, ie_q[c], os_q[c], dir_q[c], en_q[c]};
                    2'd1:    rdata_c = 32'(value_q[c]);
                    2'd2:    rdata_c = 32'(limit_q[c]);
                    default: rdata_c = {31'd0, tc_q[c]};
                endcase
            end
        end
    end

    // Channel next state: W1C, then tick (set wins over clear), then bus writes override.
    always_comb begin
        logic       hit;
        logic       cnt_en;
        logic [3:0] ctrl_w;
        hit    = 1'b0;
        cnt_en = 1'b0;
        ctrl_w = '0;
        en_d   = en_q;
        dir_d  = dir_q;
        os_d   = os_q;
        ie_d   = ie_q;
        tc_d   = tc_q;
        for (int c = 0; c < NCH; c++) begin
            value_d[c] = value_q[c];
            limit_d[c] = limit_q[c];
            hit    = wr_c && (chan_c == 4'(c));
            cnt_en = tick_c & en_q[c] & (la_oenb[c] | la_data_in[c]);
            if (hit && (reg_c == 2'd3) && wbs_sel_i[0] && wbs_dat_i[0]) tc_d[c] = 1'b0;
            // A VALUE write in the same cycle swallows the tick entirely.
            if (cnt_en && !(hit && (reg_c == 2'd1))) begin
                if (!dir_q[c]) begin
                    if (value_q[c] == limit_q[c]) begin
                        tc_d[c] = 1'b1;
                        if (os_q[c]) en_d[c] = 1'b0;
                        else         value_d[c] = '0;
                    end else begin
                        value_d[c] = value_q[c] + BITS'(1);
                    end
                end else begin
                    if (value_q[c] == '0) begin
                        tc_d[c] = 1'b1;
                        if (os_q[c]) en_d[c] = 1'b0;
                        else         value_d[c] = limit_q[c];
                    end else begin
                        value_d[c] = value_q[c] - BITS'(1);
                    end
                end
            end
            if (hit) begin
                case (reg_c)
                    2'd0: begin
                        ctrl_w = 4'(byte_merge(32'({ie_q[c], os_q[c], dir_q[c], en_q[c]}),
                                               wbs_dat_i, wbs_sel_i));
                        en_d[c]  = ctrl_w[0];
                        dir_d[c] = ctrl_w[1];
                        os_d[c]  = ctrl_w[2];
                        ie_d[c]  = ctrl_w[3];
                    end
                    2'd1:    value_d[c] = BITS'(byte_merge(32'(value_q[c]), wbs_dat_i, wbs_sel_i));
                    2'd2:    limit_d[c] = BITS'(byte_merge(32'(limit_q[c]), wbs_dat_i, wbs_sel_i));
                    default: ;
                endcase
            end
        end
    end

    // Bus response and interrupt next state.
    always_comb begin
        ack_d = acc_c;
        dat_d = (acc_c && !wbs_we_i) ? rdata_c : dat_q;
        irq_d = |(tc_q & ie_q);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_q  <= '0;
            dir_q <= '0;
            os_q  <= '0;
            ie_q  <= '0;
            tc_q  <= '0;
            ack_q <= 1'b0;
            dat_q <= '0;
            irq_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                value_q[c] <= '0;
                limit_q[c] <= '1;
            end
        end else begin
            en_q  <= en_d;
            dir_q <= dir_d;
            os_q  <= os_d;
            ie_q  <= ie_d;
            tc_q  <= tc_d;
            ack_q <= ack_d;
            dat_q <= dat_d;
            irq_q <= irq_d;
            for (int c = 0; c < NCH; c++) begin
                value_q[c] <= value_d[c];
                limit_q[c] <= limit_d[c];
            end
        end
    end

    always_comb begin
        la_data_out = '0;
        for (int c = 0; c < NCH; c++) la_data_out[c*BITS +: BITS] = value_q[c];
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = {2'b00, irq_q};
    assign io_out    = value_q[0];
    assign io_oeb    = {BITS{wb_rst_i}};

endmodule

// File: tb/tb_wb_multi_counter.sv
// tb_wb_multi_counter: directed scenarios plus randomized bus/gate traffic, every cycle
// checked against a per-channel behavioural model of the counter block.
module tb_wb_multi_counter;
    localparam int unsigned BITS = 16;
    localparam int unsigned NCH  = 4;
    localparam longint unsigned MASK = (64'd1 << BITS) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc, stb, we;
    logic [3:0]   sel;
    logic [31:0]  adr, wdat;
    logic         ack;
    logic [31:0]  rdat;
    logic [127:0] la_in, la_oe, la_out;
    logic [BITS-1:0] io_out, io_oeb;
    logic [2:0]   irq;

    always #5 clk = ~clk;

    wb_multi_counter #(.BITS(BITS), .NCH(NCH), .PSW(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .la_data_in(la_in), .la_oenb(la_oe), .la_data_out(la_out),
        .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    bit              m_en [NCH];
    bit              m_dir[NCH];
    bit              m_os [NCH];
    bit              m_ie [NCH];
    bit              m_tc [NCH];
    longint unsigned m_val[NCH];
    longint unsigned m_lim[NCH];
    bit              m_ack, m_irq;
    logic [31:0]     m_dat;
    longint unsigned m_presc, m_since;

    int exp1[5] = '{0, 1, 2, 3, 0};
    int exp2[4] = '{2, 1, 0, 0};

    task automatic m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_dir[c] = 0; m_os[c] = 0; m_ie[c] = 0; m_tc[c] = 0;
            m_val[c] = 0; m_lim[c] = MASK;
        end
        m_ack = 0; m_irq = 0; m_dat = '0; m_presc = 0; m_since = 0;
    endtask

    function automatic logic [31:0] wmerge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int ch, rg;
        ch = int'(a[7:4]);
        rg = int'(a[3:2]);
        if (ch == 15 && rg == 0) begin
`ifdef MCNT_PRESCALER_EN
            return 32'(m_presc);
`else
            return 32'd0;
`endif
        end
        if (ch >= NCH) return 32'd0;
        case (rg)
            0:       return {28'd0, m_ie[ch], m_os[ch], m_dir[ch], m_en[ch]};
            1:       return 32'(m_val[ch]);
            2:       return 32'(m_lim[ch]);
            default: return {31'd0, m_tc[ch]};
        endcase
    endfunction

    function automatic logic [127:0] m_la();
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[c*BITS +: BITS] = BITS'(m_val[c]);
        return r;
    endfunction

    // Advance the model across one rising edge, using the inputs currently driven.
    task automatic model_edge();
        bit acc, wr, tick, nirq, hit, run, set_tc;
        int ch, rg;
        logic [31:0] mv;
        acc = cyc && stb && !m_ack;
        wr  = acc && we;
        ch  = int'(adr[7:4]);
        rg  = int'(adr[3:2]);
        nirq = 0;
        for (int c = 0; c < NCH; c++) if (m_tc[c] && m_ie[c]) nirq = 1;
`ifdef MCNT_PRESCALER_EN
        tick = ((m_since % (m_presc + 1)) == m_presc);
        m_since++;
`else
        tick = 1;
`endif
        if (acc && !we) m_dat = m_read(adr);
        for (int c = 0; c < NCH; c++) begin
            hit = wr && (ch == c);
            set_tc = 0;
            run = tick && m_en[c] && (la_oe[c] || la_in[c]) && !(hit && rg == 1);
            if (run) begin
                if (!m_dir[c]) begin
                    if (m_val[c] == m_lim[c]) begin
                        set_tc = 1;
                        if (m_os[c]) m_en[c] = 0; else m_val[c] = 0;
                    end else m_val[c] = (m_val[c] + 1) & MASK;
                end else begin
                    if (m_val[c] == 0) begin
                        set_tc = 1;
                        if (m_os[c]) m_en[c] = 0; else m_val[c] = m_lim[c];
                    end else m_val[c] = (m_val[c] - 1) & MASK;
                end
            end
            if (hit) begin
                case (rg)
                    0: begin
                        mv = wmerge({28'd0, m_ie[c], m_os[c], m_dir[c], m_en[c]}, wdat, sel);
                        m_en[c] = mv[0]; m_dir[c] = mv[1]; m_os[c] = mv[2]; m_ie[c] = mv[3];
                    end
                    1: m_val[c] = wmerge(32'(m_val[c]), wdat, sel) & MASK;
                    2: m_lim[c] = wmerge(32'(m_lim[c]), wdat, sel) & MASK;
                    default: if (sel[0] && wdat[0]) m_tc[c] = 0;
                endcase
            end
            if (set_tc) m_tc[c] = 1;
        end
`ifdef MCNT_PRESCALER_EN
        if (wr && ch == 15 && rg == 0) begin
            m_presc = wmerge(32'(m_presc), wdat, sel) & 32'hFF;
            m_since = 0;
        end
`endif
        m_ack = acc;
        m_irq = nirq;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("ack", ack, m_ack);
        check("dat_o", rdat, m_dat);
        check("irq", irq, {2'b00, m_irq});
        check("la_out", la_out, m_la());
        check("io_out", io_out, m_val[0]);
        check("io_oeb", io_oeb, 0);
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        bit got;
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            if (ack) got = 1;
        end
        if (!got) check("ack_timeout", 0, 1);
        rd = rdat;
        cyc = 0; stb = 0; we = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 4'hF; adr = '0; wdat = '0;
        la_in = '0; la_oe = '1;
        m_reset();
        @(negedge clk); @(negedge clk);
        rst = 0;

        // Channel 1 up, LIMIT 3, interrupt enabled
        wb_xfer(1, 32'h18, 32'd3, 4'hF, rd);
        wb_xfer(1, 32'h10, 32'h9, 4'hF, rd);
        check("ch1_seq0", la_out[31:16], exp1[0]);
        for (int k = 1; k < 5; k++) begin
            step();
            check($sformatf("ch1_seq%0d", k), la_out[31:16], exp1[k]);
        end
        check("ch1_irq_lag", irq[0], 0);
        step();
        check("ch1_irq", irq[0], 1);
        wb_xfer(1, 32'h10, 32'h8, 4'hF, rd);
        wb_xfer(0, 32'h1C, 32'd0, 4'hF, rd);
        check("ch1_tc", rd, 32'd1);
        wb_xfer(1, 32'h1C, 32'd1, 4'hF, rd);
        step();
        check("ch1_irq_clr", irq[0], 0);

        // Channel 3, LIMIT 0, no interrupt enable
        wb_xfer(1, 32'h38, 32'd0, 4'hF, rd);
        wb_xfer(1, 32'h30, 32'h1, 4'hF, rd);
        repeat (3) step();
        check("ch3_irq_masked", irq[0], 0);
        wb_xfer(0, 32'h3C, 32'd0, 4'hF, rd);
        check("ch3_tc", rd, 32'd1);
        wb_xfer(0, 32'h34, 32'd0, 4'hF, rd);
        check("ch3_value", rd, 32'd0);
        wb_xfer(1, 32'h30, 32'h0, 4'hF, rd);
        wb_xfer(1, 32'h3C, 32'h1, 4'hF, rd);

        // Channel 2 down one-shot from 2
        wb_xfer(1, 32'h24, 32'd2, 4'hF, rd);
        wb_xfer(1, 32'h20, 32'h7, 4'hF, rd);
        check("ch2_seq0", la_out[47:32], exp2[0]);
        for (int k = 1; k < 4; k++) begin
            step();
            check($sformatf("ch2_seq%0d", k), la_out[47:32], exp2[k]);
        end
        repeat (2) step();
        wb_xfer(0, 32'h20, 32'd0, 4'hF, rd);
        check("ch2_ctrl", rd, 32'h6);
        wb_xfer(0, 32'h24, 32'd0, 4'hF, rd);
        check("ch2_value", rd, 32'd0);
        wb_xfer(0, 32'h2C, 32'd0, 4'hF, rd);
        check("ch2_tc", rd, 32'd1);

        // VALUE write lands on the terminal tick of channel 0
        wb_xfer(1, 32'h08, 32'd5, 4'hF, rd);
        wb_xfer(1, 32'h04, 32'd4, 4'hF, rd);
        wb_xfer(1, 32'h00, 32'h1, 4'hF, rd);
        step();
        check("ch0_at_limit", io_out, 16'd5);
        wb_xfer(1, 32'h04, 32'h55, 4'hF, rd);
        check("wr_beats_tick", io_out, 16'h55);
        wb_xfer(0, 32'h0C, 32'd0, 4'hF, rd);
        check("wr_beats_tick_tc", rd, 32'd0);

        // External gate on channel 0
        la_oe[0] = 1'b0; la_in[0] = 1'b0;
        wb_xfer(1, 32'h04, 32'h100, 4'hF, rd);
        repeat (3) step();
        check("gate_frozen", io_out, 16'h100);
        la_in[0] = 1'b1;
        repeat (2) step();
        check("gate_resume", io_out, 16'h102);
        la_oe = '1; la_in = '0;

`ifdef MCNT_PRESCALER_EN
        wb_xfer(1, 32'hF0, 32'd3, 4'hF, rd);
        wb_xfer(1, 32'h04, 32'd0, 4'hF, rd);
        repeat (2) step();
        check("presc_first", io_out, 16'd1);
        repeat (4) step();
        check("presc_second", io_out, 16'd2);
        wb_xfer(0, 32'hF0, 32'd0, 4'hF, rd);
        check("presc_read", rd, 32'd3);
`else
        wb_xfer(1, 32'hF0, 32'hFF, 4'hF, rd);
        wb_xfer(0, 32'hF0, 32'd0, 4'hF, rd);
        check("presc_read", rd, 32'd0);
`endif

        // Reset in the middle of counting and of an acked read
        wb_xfer(1, 32'h10, 32'h9, 4'hF, rd);
        repeat (6) step();
        check("pre_rst_irq", irq[0], 1);
        cyc = 1; stb = 1; we = 0; adr = 32'h08;
        model_edge();
        @(posedge clk); @(negedge clk);
        check("rst_pre_ack", ack, 1);
        rst = 1;
        #1;
        check("rst_ack", ack, 0);
        check("rst_dat", rdat, 0);
        check("rst_irq", irq, 0);
        check("rst_la", la_out, 0);
        check("rst_io", io_out, 0);
        check("rst_oeb", io_oeb, 16'hFFFF);
        m_reset();
        cyc = 0; stb = 0;
        @(posedge clk); @(negedge clk);
        rst = 0;
        wb_xfer(0, 32'h08, 32'd0, 4'hF, rd);
        check("rst_limit", rd, 32'h0000FFFF);
        wb_xfer(0, 32'h10, 32'd0, 4'hF, rd);
        check("rst_ctrl", rd, 32'd0);

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            la_in = {$urandom, $urandom, $urandom, $urandom};
            for (int c = 0; c < NCH; c++) la_oe[c] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) begin
                step();
            end else begin
                logic [3:0] ch;
                logic [1:0] rg;
                logic [31:0] d;
                logic [3:0] s;
                ch = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 4));
                rg = 2'($urandom_range(0, 3));
                case (rg)
                    2'd0:    d = 32'($urandom_range(0, 15));
                    2'd3:    d = 32'($urandom_range(0, 1));
                    default: d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
                endcase
                s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                wb_xfer(1'($urandom_range(0, 1)), {24'd0, ch, rg, 2'b00}, d, s, rd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
